ex_issue_skid: RTL

//  ID->EX issue stage feeding the 64-bit ALU. Accepts decoded ops from ID over valid/ready,

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_ctl_decode.sv | 32 +++
 rtl/ex_issue_skid.sv | 125 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, ALUOp classes and issue-stage types.
// Used by the EX issue stage and by the single-cycle datapath decoder.
package alu_pkg;

   localparam int ISS_XLEN   = 64;
   localparam int ISS_CTRL_W = 8;

   // 4-bit ALU control codes
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   // 2-bit ALUOp classes produced by the main decoder
   localparam logic [1:0] AOP_MEM   = 2'b00;
   localparam logic [1:0] AOP_BR    = 2'b01;
   localparam logic [1:0] AOP_RTYPE = 2'b10;
   localparam logic [1:0] AOP_RSVD  = 2'b11;

   // R-type funct codes {instr[30], instr[14:12]}
   localparam logic [3:0] FN_ADD = 4'b0000;
   localparam logic [3:0] FN_SUB = 4'b1000;
   localparam logic [3:0] FN_AND = 4'b0111;
   localparam logic [3:0] FN_OR  = 4'b0110;

   // Occupancy of the two-entry skid buffer
   typedef enum logic [1:0] {
      S_EMPTY = 2'b00,
      S_ONE   = 2'b01,
      S_TWO   = 2'b10
   } skid_state_e;

   // One held operation, already decoded and operand-B muxed
   typedef struct packed {
      logic [ISS_XLEN-1:0]   a;
      logic [ISS_XLEN-1:0]   b;
      logic [3:0]            alu_ctl;
      logic                  illegal;
      logic [4:0]            rd;
      logic [ISS_CTRL_W-1:0] ctrl;
   } issue_ent_t;

endpackage

// File: rtl/alu_ctl_decode.sv
// ALUOp + funct to 4-bit ALU control decoder.
// Purely combinational; undecodable combinations fall back to ADD.
module alu_ctl_decode
   import alu_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [3:0] funct,
   output logic [3:0] alu_ctl,
   output logic       illegal
);

   // Map operation class and funct to ALU control, flagging bad encodings
   always_comb begin
      alu_ctl = ALU_ADD;
      illegal = 1'b0;
      unique case (alu_op)
         AOP_MEM: alu_ctl = ALU_ADD;
         AOP_BR:  alu_ctl = ALU_SUB;
         AOP_RTYPE: begin
            case (funct)
               FN_ADD:  alu_ctl = ALU_ADD;
               FN_SUB:  alu_ctl = ALU_SUB;
               FN_AND:  alu_ctl = ALU_AND;
               FN_OR:   alu_ctl = ALU_OR;
               default: illegal = 1'b1;
            endcase
         end
         AOP_RSVD: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/ex_issue_skid.sv
// ID->EX issue stage with a two-entry skid buffer in front of the ALU.
// in_ready comes straight from a flop so out_ready never reaches ID combinationally.
module ex_issue_skid
   import alu_pkg::*;
#(
   parameter int XLEN   = ISS_XLEN,
   parameter int CTRL_W = ISS_CTRL_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_rs1_data,
   input  logic [XLEN-1:0]   in_rs2_data,
   input  logic [XLEN-1:0]   in_imm,
   input  logic              in_alu_src,
   input  logic [1:0]        in_alu_op,
   input  logic [3:0]        in_funct,
   input  logic [4:0]        in_rd,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_a,
   output logic [XLEN-1:0]   out_b,
   output logic [3:0]        out_alu_ctl,
   output logic [4:0]        out_rd,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic              out_illegal
);

   skid_state_e state_q, state_d;
   issue_ent_t  main_q, main_d;
   issue_ent_t  skid_q, skid_d;
   logic        in_ready_q, in_ready_d;

   logic        dec_illegal;
   logic [3:0]  dec_ctl;
   issue_ent_t  in_ent;
   logic        fire_in;
   logic        fire_out;

   alu_ctl_decode u_dec (
      .alu_op  (in_alu_op),
      .funct   (in_funct),
      .alu_ctl (dec_ctl),
      .illegal (dec_illegal)
   );

   // Build the entry for the incoming op: operand-B mux plus decoded control
   always_comb begin
      in_ent         = '0;
      in_ent.a       = in_rs1_data;
      in_ent.b       = in_alu_src ? in_imm : in_rs2_data;
      in_ent.alu_ctl = dec_ctl;
      in_ent.illegal = dec_illegal;
      in_ent.rd      = in_rd;
      in_ent.ctrl    = in_ctrl;
   end

   assign fire_in  = in_valid && in_ready_q;
   assign fire_out = out_valid && out_ready;

   // Occupancy transitions and entry movement; flush beats everything
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = S_EMPTY;
      end else begin
         unique case (state_q)
            S_EMPTY: begin
               if (fire_in) begin
                  main_d  = in_ent;
                  state_d = S_ONE;
               end
            end
            S_ONE: begin
               if (fire_out && fire_in) begin
                  main_d = in_ent;
               end else if (fire_out) begin
                  state_d = S_EMPTY;
               end else if (fire_in) begin
                  skid_d  = in_ent;
                  state_d = S_TWO;
               end
            end
            S_TWO: begin
               if (fire_out) begin
                  main_d  = skid_q;
                  state_d = S_ONE;
               end
            end
            default: state_d = S_EMPTY;
         endcase
      end
      in_ready_d = (state_d != S_TWO);
   end

   // State, payload and registered ready
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = (state_q != S_EMPTY);
   assign out_a       = main_q.a;
   assign out_b       = main_q.b;
   assign out_alu_ctl = main_q.alu_ctl;
   assign out_illegal = main_q.illegal;
   assign out_rd      = main_q.rd;
   assign out_ctrl    = main_q.ctrl;

endmodule
